// File: rtl/huff_stream_encoder.sv
// huff_stream_encoder: packs table-driven Huffman codewords into an MSB-first
// bitstream of OUT_WIDTH-bit words with valid/ready handshakes on both sides.
// Optional feature: define HUFF_ENC_STATS_EN to add the stat_bits counter port.
module huff_stream_encoder #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned TOTAL_SYMBOLS = 10,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned MAXHIGHT      = 10,
   parameter int unsigned OUT_WIDTH     = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [TOTAL_SYMBOLS*DATA_WIDTH-1:0] tbl_sym,
   input  logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] tbl_len,
   input  logic [TOTAL_SYMBOLS*MAXHIGHT-1:0]   tbl_code,
   input  logic                                tbl_done,
   input  logic [DATA_WIDTH-1:0]               sym_in,
   input  logic                                sym_valid,
   output logic                                sym_ready,
   input  logic                                flush,
   output logic [OUT_WIDTH-1:0]                out_word,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                out_last,
   output logic [$clog2(OUT_WIDTH):0]          out_bits,
`ifdef HUFF_ENC_STATS_EN
   output logic [31:0]                         stat_bits,
`endif
   output logic                                err_miss
);

   localparam int unsigned AccWidth  = OUT_WIDTH + MAXHIGHT - 1;
   localparam int unsigned FillWidth = $clog2(AccWidth + 1);
   localparam int unsigned BitsWidth = $clog2(OUT_WIDTH) + 1;

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StFlush, StLast} state_e;

   state_e                          state_q, state_d;
   logic [AccWidth-1:0]             acc_q, acc_d;
   logic [FillWidth-1:0]            fill_q, fill_d;
   logic                            err_miss_q, err_miss_d;
   logic                            load_tbl;
   logic [TOTAL_SYMBOLS*DATA_WIDTH-1:0] sym_tbl_q;
   logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] len_tbl_q;
   logic [TOTAL_SYMBOLS*MAXHIGHT-1:0]   code_tbl_q;

   logic                  match;
   logic                  hit;
   logic [ADDR_WIDTH-1:0] hit_len;
   logic [MAXHIGHT-1:0]   hit_code;
   logic [MAXHIGHT-1:0]   code_masked;
   logic [AccWidth-1:0]   code_aligned;
   logic                  full;
   logic                  sym_fire;
   logic                  out_fire;

   // Parallel table lookup; the first (lowest-index) match wins.
   always_comb begin
      match    = 1'b0;
      hit_len  = '0;
      hit_code = '0;
      for (int i = 0; i < TOTAL_SYMBOLS; i++) begin
         if (!match && (sym_tbl_q[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] == sym_in)) begin
            match    = 1'b1;
            hit_len  = len_tbl_q[(i+1)*ADDR_WIDTH-1 -: ADDR_WIDTH];
            hit_code = code_tbl_q[(i+1)*MAXHIGHT-1 -: MAXHIGHT];
         end
      end
      hit = match && (hit_len != '0) && (32'(hit_len) <= MAXHIGHT);
   end

   // Keep only the low len code bits, left-align them, then place them just below fill.
   always_comb begin
      code_masked  = hit_code & ~({MAXHIGHT{1'b1}} << hit_len);
      code_aligned = ({code_masked, {(AccWidth-MAXHIGHT){1'b0}}}
                      << (ADDR_WIDTH'(MAXHIGHT) - hit_len)) >> fill_q;
   end

   assign full     = (fill_q >= FillWidth'(OUT_WIDTH));
   assign sym_fire = sym_valid && sym_ready;
   assign out_fire = out_valid && out_ready;
   assign err_miss = err_miss_q;

   // Next-state, accumulator update and handshake outputs.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      fill_d     = fill_q;
      err_miss_d = err_miss_q;
      load_tbl   = 1'b0;
      sym_ready  = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_word   = '0;
      out_bits   = '0;
      case (state_q)
         StIdle: begin
            if (tbl_done) state_d = StLoad;
         end
         StLoad: begin
            load_tbl = 1'b1;
            acc_d    = '0;
            fill_d   = '0;
            state_d  = StRun;
         end
         StRun: begin
            // Acceptance (fill below a word) and emission (a full word) never overlap.
            sym_ready = !full;
            out_valid = full;
            if (full) out_word = acc_q[AccWidth-1 -: OUT_WIDTH];
            if (sym_fire) begin
               if (hit) begin
                  acc_d  = acc_q | code_aligned;
                  fill_d = fill_q + FillWidth'(hit_len);
               end else begin
                  err_miss_d = 1'b1;
               end
            end
            if (out_fire) begin
               acc_d  = acc_q << OUT_WIDTH;
               fill_d = fill_q - FillWidth'(OUT_WIDTH);
            end
            if (flush) state_d = StFlush;
         end
         StFlush: begin
            out_valid = full;
            if (full) out_word = acc_q[AccWidth-1 -: OUT_WIDTH];
            if (out_fire) begin
               acc_d  = acc_q << OUT_WIDTH;
               fill_d = fill_q - FillWidth'(OUT_WIDTH);
            end
            if (!full) state_d = StLast;
         end
         StLast: begin
            // Bits below fill are always zero, so the top slice is already padded.
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_word  = acc_q[AccWidth-1 -: OUT_WIDTH];
            out_bits  = BitsWidth'(fill_q);
            if (out_fire) begin
               acc_d   = '0;
               fill_d  = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, accumulator and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         fill_q     <= '0;
         err_miss_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         fill_q     <= fill_d;
         err_miss_q <= err_miss_d;
      end
   end

   // Table snapshot taken in the load cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sym_tbl_q  <= '0;
         len_tbl_q  <= '0;
         code_tbl_q <= '0;
      end else if (load_tbl) begin
         sym_tbl_q  <= tbl_sym;
         len_tbl_q  <= tbl_len;
         code_tbl_q <= tbl_code;
      end
   end

`ifdef HUFF_ENC_STATS_EN
   logic [31:0] stat_q, stat_d;
   logic [32:0] stat_sum;

   // Saturating count of encoded bits, cleared when the last word is taken.
   always_comb begin
      stat_d   = stat_q;
      stat_sum = {1'b0, stat_q} + 33'(hit_len);
      if ((state_q == StRun) && sym_fire && hit) begin
         stat_d = stat_sum[32] ? 32'hFFFF_FFFF : stat_sum[31:0];
      end
      if ((state_q == StLast) && out_fire) stat_d = '0;
   end

   // Statistics register.
   always_ff @(posedge clk) begin
      if (rst) stat_q <= '0;
      else     stat_q <= stat_d;
   end

   assign stat_bits = stat_q;
`endif

endmodule
